// File: rtl/frame_tick_scheduler.sv
// frame_tick_scheduler: frame tick generator with pause, queued single-step, busy deferral and overrun flag.
// Optional SLOW_MOTION_EN macro enables the i_speed rate divider (1x .. 1/8x).
module frame_tick_scheduler #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int FRAME_HZ     = 60,
  parameter int STEP_DEPTH   = 4,
  parameter int FRAME_W      = 16,
  parameter bit START_PAUSED = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_play_pause,
  input  logic               i_frame_by_frame,
  input  logic [1:0]         i_speed,
  input  logic               i_frame_busy,
  output logic               o_cal_frame_signal,
  output logic               o_paused,
  output logic [FRAME_W-1:0] o_frame_idx,
  output logic               o_overrun
);
  localparam int PERIOD = CLK_HZ / FRAME_HZ;
  localparam int PW = PERIOD > 1 ? $clog2(PERIOD) : 1;
  localparam int QW = $clog2(STEP_DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(PERIOD - 1);
  localparam logic [QW-1:0] QMAX = QW'(STEP_DEPTH);
  logic [PW-1:0] pcnt;
  logic [QW-1:0] q;
  logic pending, wrap, req, play_src, can, issue, step_acc, step_iss;
  assign wrap = !o_paused && pcnt == LAST;
`ifdef SLOW_MOTION_EN
  logic [2:0] dcnt, lim;
  assign lim = ~(3'b111 << i_speed);
  // >= lets a lowered speed fire at the very next wrap instead of waiting out the old window
  assign req = wrap && dcnt >= lim;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) dcnt <= '0;
    else if (wrap) dcnt <= dcnt >= lim ? '0 : dcnt + 3'd1;
`else
  logic unused_speed;
  assign unused_speed = ^i_speed;
  assign req = wrap;
`endif
  assign play_src = pending || req;
  assign can = !i_frame_busy && !o_cal_frame_signal;
  assign issue = can && (play_src || q != '0);
  assign step_iss = can && !play_src && q != '0;
  assign step_acc = o_paused && i_frame_by_frame && !i_play_pause && q != QMAX;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_paused           <= START_PAUSED;
      pcnt               <= '0;
      q                  <= '0;
      pending            <= 1'b0;
      o_cal_frame_signal <= 1'b0;
      o_frame_idx        <= '0;
      o_overrun          <= 1'b0;
    end else begin
      o_paused           <= o_paused ^ i_play_pause;
      if (!o_paused) pcnt <= wrap ? '0 : pcnt + 1'b1;
      pending            <= can ? pending && req : play_src;
      o_overrun          <= !can && pending && req;
      o_cal_frame_signal <= issue;
      if (issue) o_frame_idx <= o_frame_idx + 1'b1;
      q                  <= (o_paused && i_play_pause) ? '0 : q + QW'(step_acc) - QW'(step_iss);
    end
endmodule

// File: tb/tb_frame_tick_scheduler.sv
// tb_frame_tick_scheduler: phase-table bench; each row drives inputs for n cycles and checks tick/overrun deltas and state.
module tb_frame_tick_scheduler;
  localparam int FW = 4;
  logic clk = 0, rst_n = 0, pp = 0, fbf = 0, busy = 0;
  logic [1:0] speed = 0;
  logic tick, paused, ov;
  logic [FW-1:0] idx;
  int checks = 0, errors = 0;
  int n_tick = 0, n_ov = 0, n_consec = 0;
  logic prev = 0;

  frame_tick_scheduler #(.CLK_HZ(600), .FRAME_HZ(60), .STEP_DEPTH(4), .FRAME_W(FW), .START_PAUSED(1'b0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_play_pause(pp), .i_frame_by_frame(fbf), .i_speed(speed),
    .i_frame_busy(busy), .o_cal_frame_signal(tick), .o_paused(paused), .o_frame_idx(idx), .o_overrun(ov)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tick) n_tick++;
    if (ov) n_ov++;
    if (tick && prev) n_consec++;
    prev = tick;
  end

  typedef struct {
    logic pp, fbf, busy;
    logic [1:0] speed;
    int n, et, eo;
    logic ep;
    int ei;
  } row_t;
  row_t rows[$];

  task automatic add(input logic a_pp, a_fbf, a_busy, input logic [1:0] a_sp, input int a_n, a_et, a_eo,
                     input logic a_ep, input int a_ei);
    row_t r;
    r.pp = a_pp; r.fbf = a_fbf; r.busy = a_busy; r.speed = a_sp;
    r.n = a_n; r.et = a_et; r.eo = a_eo; r.ep = a_ep; r.ei = a_ei;
    rows.push_back(r);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int t0, o0, c0;
    add(0, 0, 0, 0, 30, 3, 0, 0, 3);
    add(0, 0, 1, 0, 30, 0, 2, 0, 3);
    add(0, 0, 0, 0,  5, 1, 0, 0, 4);
    add(1, 0, 0, 0, 10, 0, 0, 1, 4);
    for (int k = 0; k < 6; k++) add(0, 1, 1, 0, 1, 0, 0, 1, 4);
    add(0, 0, 0, 0, 12, 4, 0, 1, 8);
    add(0, 0, 0, 0, 10, 0, 0, 1, 8);
    add(0, 1, 1, 0,  1, 0, 0, 1, 8);
    add(0, 1, 1, 0,  1, 0, 0, 1, 8);
    add(1, 0, 1, 0,  2, 0, 0, 0, 8);
    add(0, 0, 0, 0,  2, 0, 0, 0, 8);
    add(0, 0, 0, 0,  1, 1, 0, 0, 9);
    add(0, 0, 0, 0, 10, 1, 0, 0, 10);
    add(1, 1, 0, 0, 10, 0, 0, 1, 10);
    add(0, 0, 0, 0, 10, 0, 0, 1, 10);
    add(1, 0, 0, 0, 10, 1, 0, 0, 11);
    add(0, 0, 0, 0, 50, 5, 0, 0, 0);
`ifdef SLOW_MOTION_EN
    add(0, 0, 0, 2, 39, 0, 0, 0, 0);
    add(0, 0, 0, 2,  1, 1, 0, 0, 1);
    add(0, 0, 0, 2, 20, 0, 0, 0, 1);
    add(0, 0, 0, 0, 10, 1, 0, 0, 2);
`else
    add(0, 0, 0, 3, 10, 1, 0, 0, 1);
    add(0, 0, 0, 2, 10, 1, 0, 0, 2);
`endif
    #2;
    chk("reset_tick", int'(tick), 0);
    chk("reset_paused", int'(paused), 0);
    chk("reset_idx", int'(idx), 0);
    chk("reset_overrun", int'(ov), 0);
    @(negedge clk); #1 rst_n = 1;
    foreach (rows[r]) begin
      t0 = n_tick; o0 = n_ov; c0 = n_consec;
      pp = rows[r].pp; fbf = rows[r].fbf; busy = rows[r].busy; speed = rows[r].speed;
      repeat (rows[r].n) begin
        @(posedge clk); #1 pp = 0; fbf = 0;
      end
      @(negedge clk); #1;
      chk($sformatf("row%0d_ticks", r), n_tick - t0, rows[r].et);
      chk($sformatf("row%0d_overruns", r), n_ov - o0, rows[r].eo);
      chk($sformatf("row%0d_paused", r), int'(paused), int'(rows[r].ep));
      chk($sformatf("row%0d_idx", r), int'(idx), rows[r].ei);
      chk($sformatf("row%0d_back_to_back", r), n_consec - c0, 0);
    end
    busy = 0; speed = 0;
    #2 rst_n = 0;
    #1;
    chk("midreset_tick", int'(tick), 0);
    chk("midreset_idx", int'(idx), 0);
    chk("midreset_paused", int'(paused), 0);
    chk("midreset_overrun", int'(ov), 0);
    @(negedge clk); #1 rst_n = 1;
    t0 = n_tick;
    repeat (9) @(posedge clk);
    @(negedge clk); #1;
    chk("after_reset_no_early_tick", n_tick - t0, 0);
    @(posedge clk);
    @(negedge clk); #1;
    chk("after_reset_first_tick", n_tick - t0, 1);
    chk("after_reset_idx", int'(idx), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
